// File: rtl/reg_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_ctrl_pkg
// Brief    : Opcodes, ALU ops, FSM encoding and control bundle for reg_alu_ctrl
// Revision : 1.0
// ============================================================================
package reg_alu_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int STATE_W = 3;

  localparam logic [1:0] OPC_LDI = 2'b00;
  localparam logic [1:0] OPC_ALU = 2'b01;
  localparam logic [1:0] OPC_RD  = 2'b10;
  localparam logic [1:0] OPC_RSV = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_FETCH = 3'd0;
  localparam state_t ST_IMM   = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_READ  = 3'd4;
  localparam state_t ST_RESP  = 3'd5;

  typedef struct packed {
    logic              sel;
    logic              wr;
    logic [1:0]        op;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] wr_addr;
  } ctrl_t;

  function automatic logic [1:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[15:14];
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_ctrl_decode
// Brief    : Maps FSM state plus latched instruction fields to datapath controls
// Revision : 1.0
// ============================================================================
module reg_alu_ctrl_decode
  import reg_alu_ctrl_pkg::*;
(
  input  logic         en,
  input  state_t       state,
  input  logic [13:3]  ir,
  output ctrl_t        ctrl
);

  always_comb begin
    ctrl = '0;
    // en low forces every control to its idle value, so reset never writes
    if (en) begin
      case (state)
        ST_WRITE: begin
          ctrl.wr      = 1'b1;
          ctrl.sel     = 1'b0;
          ctrl.wr_addr = ir[13:11];
        end
        ST_EXEC: begin
          ctrl.wr        = 1'b1;
          ctrl.sel       = 1'b1;
          ctrl.op        = ir[13:12];
          ctrl.rd_addr_a = ir[8:6];
          ctrl.rd_addr_b = ir[5:3];
          ctrl.wr_addr   = ir[11:9];
        end
        ST_READ: begin
          ctrl.rd_addr_a = ir[8:6];
          ctrl.rd_addr_b = ir[5:3];
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_ctrl
// Brief    : Instruction sequencer driving the reg_alu register file / ALU
// Revision : 1.0
// ============================================================================
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_a,
  output logic [DATA_W-1:0] res_b,
  input  logic              res_ready,
  output logic              carry,
  output logic              illegal,
  output logic              sel,
  output logic              wr,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] d_out_a,
  input  logic [DATA_W-1:0] d_out_b,
  input  logic              cout
);

  state_t             r_state;
  state_t             w_next;
  logic [13:3]        r_ir;
  logic [DATA_W-1:0]  r_d_in;
  logic [DATA_W-1:0]  r_res_a;
  logic [DATA_W-1:0]  r_res_b;
  logic               r_carry;
  logic               r_illegal;
  logic               w_accept;
  ctrl_t              w_ctrl;

  assign w_accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_accept) begin
          case (opcode_of(instr))
            OPC_LDI: w_next = ST_IMM;
            OPC_ALU: w_next = ST_EXEC;
            OPC_RD:  w_next = ST_READ;
            default: w_next = ST_FETCH;
          endcase
        end
      end
      ST_IMM:   if (w_accept) w_next = ST_WRITE;
      ST_WRITE: w_next = ST_FETCH;
      ST_EXEC:  w_next = ST_FETCH;
      ST_READ:  w_next = ST_RESP;
      ST_RESP:  if (res_ready) w_next = ST_FETCH;
      default:  w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    if (!reset) begin
      instr_ready = (r_state == ST_FETCH) || (r_state == ST_IMM);
      res_valid   = (r_state == ST_RESP);
    end
  end

  // Header lands in r_ir; the immediate word bypasses it into r_d_in
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir      <= '0;
      r_d_in    <= '0;
      r_res_a   <= '0;
      r_res_b   <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept && r_state == ST_FETCH) begin
        r_ir <= instr[13:3];
        if (opcode_of(instr) == OPC_RSV) r_illegal <= 1'b1;
      end
      if (w_accept && r_state == ST_IMM) r_d_in <= instr;
      if (r_state == ST_EXEC) r_carry <= cout;
      if (r_state == ST_READ) begin
        r_res_a <= d_out_a;
        r_res_b <= d_out_b;
      end
    end
  end

  reg_alu_ctrl_decode u_decode (
    .en    (!reset),
    .state (r_state),
    .ir    (r_ir),
    .ctrl  (w_ctrl)
  );

  assign sel       = w_ctrl.sel;
  assign wr        = w_ctrl.wr;
  assign op        = w_ctrl.op;
  assign rd_addr_a = w_ctrl.rd_addr_a;
  assign rd_addr_b = w_ctrl.rd_addr_b;
  assign wr_addr   = w_ctrl.wr_addr;
  assign d_in      = r_d_in;
  assign res_a     = r_res_a;
  assign res_b     = r_res_b;
  assign carry     = r_carry;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_alu_ctrl
// Brief    : Directed bench for reg_alu_ctrl driving a behavioural reg_alu
// Revision : 1.0
// ============================================================================
module tb_reg_alu_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        res_valid;
  logic [15:0] res_a;
  logic [15:0] res_b;
  logic        res_ready;
  logic        carry;
  logic        illegal;
  logic        sel;
  logic        wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic [15:0] d_out_a;
  logic [15:0] d_out_b;
  logic        cout;

  int n_vec;
  int n_fail;
  logic [31:0] sb[$];

  reg_alu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .res_valid   (res_valid),
    .res_a       (res_a),
    .res_b       (res_b),
    .res_ready   (res_ready),
    .carry       (carry),
    .illegal     (illegal),
    .sel         (sel),
    .wr          (wr),
    .op          (op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .d_out_a     (d_out_a),
    .d_out_b     (d_out_b),
    .cout        (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reg_alu: 8x16 register file, async reads, ALU on the read ports
  logic [15:0] rf [8];
  logic [15:0] alu_y;
  logic        alu_c;

  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];
  assign cout    = alu_c;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (op)
      2'b00: {alu_c, alu_y} = {1'b0, d_out_a} + {1'b0, d_out_b};
      2'b01: {alu_c, alu_y} = {1'b0, d_out_a} - {1'b0, d_out_b};
      2'b10: alu_y = d_out_a & d_out_b;
      default: alu_y = d_out_a | d_out_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr) begin
      rf[wr_addr] <= sel ? alu_y : d_in;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = w;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic ldi(input logic [2:0] dst, input logic [15:0] imm);
    send({2'b00, dst, 11'd0});
    send(imm);
  endtask

  task automatic alu(input logic [1:0] aop, input logic [2:0] dst,
                     input logic [2:0] sa, input logic [2:0] sb_addr);
    send({2'b01, aop, dst, sa, sb_addr, 3'd0});
    @(negedge clk);
    chk("exec_ctrl", {59'd0, wr, sel, op, wr_addr == dst},
        {59'd0, 1'b1, 1'b1, aop, 1'b1});
    chk("exec_raddr", {58'd0, rd_addr_a, rd_addr_b}, {58'd0, sa, sb_addr});
  endtask

  task automatic rd(input logic [2:0] sa, input logic [2:0] sb_addr,
                    input logic [15:0] ea, input logic [15:0] eb, input int hold);
    logic [31:0] e;
    logic [15:0] snap;
    sb.push_back({ea, eb});
    send({2'b10, 5'd0, sa, sb_addr, 3'd0});
    @(negedge clk);
    chk("rd_lat_read", {63'd0, res_valid}, 64'd0);
    @(negedge clk);
    chk("rd_lat_resp", {63'd0, res_valid}, 64'd1);
    snap = res_a;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("resp_hold", {46'd0, res_a, res_valid, instr_ready}, {46'd0, snap, 1'b1, 1'b0});
    end
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("rd_data", {32'd0, res_a, res_b}, {32'd0, e});
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("resp_done", {62'd0, res_valid, instr_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctrl", {49'd0, instr_ready, res_valid, carry, illegal, wr, sel, op,
                     rd_addr_a, rd_addr_b, wr_addr}, 64'd0);
    chk("rst_data", {16'd0, res_a, res_b, d_in}, 64'd0);
  endtask

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    res_ready   = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, instr_ready}, 64'd1);

    // Load and read back
    ldi(3'd1, 16'h0005);
    @(negedge clk);
    chk("ldi_write", {31'd0, wr, sel, wr_addr, d_in, 11'd0},
        {31'd0, 1'b1, 1'b0, 3'd1, 16'h0005, 11'd0});
    rd(3'd1, 3'd0, 16'h0005, 16'h0000, 0);

    // ALU add; stray res_ready outside RESP must have no effect
    ldi(3'd2, 16'h0003);
    res_ready = 1'b1;
    alu(2'b00, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    res_ready = 1'b0;
    chk("add_carry", {62'd0, carry, res_valid}, 64'd0);
    rd(3'd3, 3'd3, 16'h0008, 16'h0008, 0);

    // Carry and aliasing
    ldi(3'd4, 16'hFFFF);
    ldi(3'd5, 16'h0001);
    alu(2'b00, 3'd4, 3'd4, 3'd5);
    @(negedge clk);
    chk("alias_carry", {63'd0, carry}, 64'd1);
    rd(3'd4, 3'd5, 16'h0000, 16'h0001, 0);

    // Immediate backpressure
    send({2'b00, 3'd6, 11'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("imm_wait", {62'd0, wr, instr_ready}, {62'd0, 1'b0, 1'b1});
    end
    send(16'h1234);
    @(negedge clk);
    chk("imm_write", {31'd0, wr, sel, wr_addr, d_in, 11'd0},
        {31'd0, 1'b1, 1'b0, 3'd6, 16'h1234, 11'd0});

    // Result backpressure
    rd(3'd6, 3'd6, 16'h1234, 16'h1234, 4);

    // Reserved opcode
    send(16'hC000);
    @(negedge clk);
    chk("reserved", {61'd0, illegal, wr, instr_ready}, {61'd0, 1'b1, 1'b0, 1'b1});
    rd(3'd1, 3'd2, 16'h0005, 16'h0003, 0);
    chk("illegal_sticky", {63'd0, illegal}, 64'd1);

    // Reset while waiting for an immediate
    send({2'b00, 3'd1, 11'd0});
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = 16'hBEEF;
    @(negedge clk);
    chk_reset_outputs();
    reset       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst2", {63'd0, instr_ready}, 64'd1);
    rd(3'd1, 3'd0, 16'h0000, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_alu_ctrl.md
# reg_alu_ctrl

Instruction sequencer that drives the `reg_alu` datapath: the initiator side of its control interface. It accepts 16-bit instruction words over a valid/ready stream and decodes them into register-file and ALU control (`sel`, `wr`, `op`, addresses, `d_in`). It returns register read-backs over a second valid/ready stream. It sits between a host/test driver and one `reg_alu` instance and is the only master of that datapath.

## Interface
- No parameters. Data width is fixed at 16 bits, register address at 3 bits.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction word valid.
- `instr` in 16: instruction or immediate word.
- `instr_ready` out 1: controller accepts `instr` this cycle.
- `res_valid` out 1: read-back result valid.
- `res_a` out 16: register value read via `srcA`.
- `res_b` out 16: register value read via `srcB`.
- `res_ready` in 1: consumer accepts result.
- `carry` out 1: ALU carry captured by the last ALU instruction.
- `illegal` out 1: sticky; set when a reserved opcode is received.
- `sel` out 1: 0 = write `d_in`, 1 = write ALU result.
- `wr` out 1: register-file write enable.
- `op` out 2: ALU operation.
- `rd_addr_a` out 3: datapath read address A.
- `rd_addr_b` out 3: datapath read address B.
- `wr_addr` out 3: datapath write address.
- `d_in` out 16: immediate data to the datapath.
- `d_out_a` in 16: datapath read port A.
- `d_out_b` in 16: datapath read port B.
- `cout` in 1: ALU carry.

## Operation
- Instruction format is selected by `instr[15:14]`:
  - **00 LDI**: `dst` = `[13:11]`. The next accepted word is the 16-bit immediate.
  - **01 ALU**: `op` = `[13:12]`, `dst` = `[11:9]`, `srcA` = `[8:6]`, `srcB` = `[5:3]`.
  - **10 RD**: `srcA` = `[8:6]`, `srcB` = `[5:3]`.
  - **11**: reserved. Treated as a NOP and sets `illegal`.
- A word is accepted on any cycle where `instr_valid && instr_ready`. The accepted word is latched into an instruction register.
- FSM states:
  - **FETCH**: `instr_ready`=1. LDI -> IMM; ALU -> EXEC; RD -> READ; reserved -> FETCH with `illegal` set.
  - **IMM**: `instr_ready`=1. On accept, the immediate goes to the `d_in` register -> WRITE. With no valid word, wait indefinitely.
  - **WRITE**: `wr`=1, `sel`=0, `wr_addr`=`dst`. -> FETCH.
  - **EXEC**: `wr`=1, `sel`=1, `op`, `rd_addr_a`=`srcA`, `rd_addr_b`=`srcB`, `wr_addr`=`dst`. `carry` <= `cout` at the closing edge. -> FETCH.
  - **READ**: read addresses driven. `res_a`/`res_b` <= `d_out_a`/`d_out_b` at the closing edge. -> RESP.
  - **RESP**: `res_valid`=1; `res_a`/`res_b` held stable. On `res_ready` -> FETCH.
- Control outputs are decoded from state plus the instruction register only, never from `instr` directly.
- `wr`=1 occurs only in WRITE and EXEC.
- An ALU instruction with `dst` equal to `srcA` or `srcB` reads the pre-write value and writes at the clock edge.

## Timing
- Reset values:
  - State is FETCH.
  - `instr_ready`=0 while `reset` is high, 1 in the first cycle after.
  - `res_valid`=0, `res_a`=`res_b`=0, `carry`=0, `illegal`=0, `wr`=0, `sel`=0, `op`=0.
  - All addresses 0, `d_in`=0.
- Reset mid-operation: a pending immediate or unconsumed result is discarded. `wr` is 0 in the reset cycle, so no partial write occurs.
- Latency:
  - ALU: 2 cycles per instruction (accept, EXEC).
  - LDI: at least 3 cycles (header, immediate, WRITE).
  - RD: `res_valid` rises 2 cycles after accept (READ, then RESP).
- `res_ready` held high: RESP lasts exactly 1 cycle.
- `res_ready` low: RESP holds indefinitely and `instr_ready`=0 throughout.
- `res_ready` asserted outside RESP is ignored.
- `illegal` clears only on reset.

## Structure
- Shared package `reg_alu_ctrl_pkg` holds:
  - opcode constants `OPC_LDI`, `OPC_ALU`, `OPC_RD`, `OPC_RSV`;
  - the FSM state encoding;
  - ALU op constants matching `alu` (`00` = add).
- One natural combinational sub-module, `reg_alu_ctrl_decode`, maps state plus the instruction register to the `sel`/`wr`/`op`/address outputs.
- The top-level `reg_alu_ctrl` holds the FSM and registers.

## Test plan
- Bench drives a real `reg_alu` alongside the controller.
- **Load and read back**: LDI r1, 0x0005; RD srcA=1, srcB=0 -> `res_a`=0x0005, `res_b`=0x0000, `res_valid` 2 cycles after the RD accept.
- **ALU add**: LDI r1=0x0005; LDI r2=0x0003; ALU op=00, dst=3, srcA=1, srcB=2; RD 3,3 -> `res_a`=`res_b`=0x0008, `carry`=0.
- **Carry and aliasing**: LDI r4=0xFFFF; LDI r5=0x0001; ALU add dst=4, srcA=4, srcB=5 -> r4=0x0000, `carry`=1.
- **Backpressure**:
  - `instr_valid` low for 5 cycles after an LDI header -> stays in IMM with no `wr`.
  - `res_ready` low for 4 cycles in RESP -> `res_a` stable and `instr_ready`=0.
- **Reserved opcode**: `instr`=0xC000 -> `illegal`=1, no `wr`, next word accepted the following cycle.
- **Reset mid-LDI**: `reset` asserted in IMM, then RD r1 -> r1 reads 0x0000 and all outputs are at their reset values in the reset cycle.
